axi_lite_slave_regs: RTL and testbench

- AXI4-Lite responder (slave) holding NREG 32-bit control/status registers; it is the counterpart of the core's AXI master.
- Terminates read/write transactions from the interconnect and exposes register contents plus per-register write/read strobes to peripheral logic (UART/IO control).
- Handles independent AW/W arrival, byte strobes, out-of-range decode errors, and back-pressure on B and R.

---
 rtl/axi_lite_slave_regs.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register slave: NREG 32-bit registers with per-register write/read strobes.
// Optional macro AXI_SLAVE_PROT_EN rejects unprivileged (prot[0]=0) accesses with SLVERR.
module axi_lite_slave_regs #(
  parameter int unsigned AXI_DATAW      = 32,
  parameter int unsigned AXI_ADDRW      = 4,
  parameter int unsigned AXI_DATAW_BYTE = AXI_DATAW >> 3,
  parameter int unsigned NREG           = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDRW-1:0]      awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_DATAW-1:0]      wdata,
  input  logic [AXI_DATAW_BYTE-1:0] wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AXI_ADDRW-1:0]      araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [AXI_DATAW-1:0]      rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [NREG*AXI_DATAW-1:0] reg_q,
  output logic [NREG-1:0]           wr_pulse,
  output logic [NREG-1:0]           rd_pulse
);

  localparam int unsigned IDXW        = AXI_ADDRW - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_COLLECT, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  w_state_e                  w_state_q, w_state_d;
  logic                      aw_have_q, aw_have_d;
  logic [IDXW-1:0]           aw_idx_q, aw_idx_d;
  logic                      aw_priv_q, aw_priv_d;
  logic                      w_have_q, w_have_d;
  logic [AXI_DATAW-1:0]      wdata_q, wdata_d;
  logic [AXI_DATAW_BYTE-1:0] wstrb_q, wstrb_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [NREG*AXI_DATAW-1:0] regs_q, regs_d;
  logic [NREG-1:0]           wr_pulse_q, wr_pulse_d;

  r_state_e                  r_state_q, r_state_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATAW-1:0]      rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [NREG-1:0]           rd_pulse_q, rd_pulse_d;

  logic                      aw_hs_c, w_hs_c, ar_hs_c;
  logic [IDXW-1:0]           aw_idx_c, ar_idx_c;
  logic [AXI_DATAW-1:0]      wdata_c;
  logic [AXI_DATAW_BYTE-1:0] wstrb_c;
  logic                      wr_prot_ok_c, rd_prot_ok_c, wr_ok_c, rd_ok_c;
  logic                      unused_bits;

  assign aw_hs_c  = awvalid && awready_q;
  assign w_hs_c   = wvalid && wready_q;
  assign ar_hs_c  = arvalid && arready_q;

  // Commit uses the beat arriving this edge when it is not already latched.
  assign aw_idx_c = aw_have_q ? aw_idx_q : awaddr[AXI_ADDRW-1:2];
  assign wdata_c  = w_have_q ? wdata_q : wdata;
  assign wstrb_c  = w_have_q ? wstrb_q : wstrb;
  assign ar_idx_c = araddr[AXI_ADDRW-1:2];

`ifdef AXI_SLAVE_PROT_EN
  assign wr_prot_ok_c = aw_have_q ? aw_priv_q : awprot[0];
  assign rd_prot_ok_c = arprot[0];
  assign unused_bits  = ^{awprot[2:1], arprot[2:1], awaddr[1:0], araddr[1:0]};
`else
  assign wr_prot_ok_c = 1'b1;
  assign rd_prot_ok_c = 1'b1;
  assign unused_bits  = ^{awprot, arprot, aw_priv_q, awaddr[1:0], araddr[1:0]};
`endif

  assign wr_ok_c = (32'(aw_idx_c) < NREG) && wr_prot_ok_c;
  assign rd_ok_c = (32'(ar_idx_c) < NREG) && rd_prot_ok_c;

  // Write path: collect AW and W independently, commit once both are present.
  always_comb begin
    w_state_d  = w_state_q;
    aw_have_d  = aw_have_q;
    aw_idx_d   = aw_idx_q;
    aw_priv_d  = aw_priv_q;
    w_have_d   = w_have_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs_c) begin
          aw_have_d = 1'b1;
          aw_idx_d  = awaddr[AXI_ADDRW-1:2];
          aw_priv_d = awprot[0];
        end
        if (w_hs_c) begin
          w_have_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if ((aw_have_q || aw_hs_c) && (w_have_q || w_hs_c)) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          if (wr_ok_c) begin
            for (int unsigned i = 0; i < NREG; i++) begin
              if (32'(aw_idx_c) == i) begin
                wr_pulse_d[i +: 1] = 1'b1;
                for (int unsigned k = 0; k < AXI_DATAW_BYTE; k++) begin
                  if (wstrb_c[k +: 1] == 1'b1) begin
                    regs_d[i*AXI_DATAW + 8*k +: 8] = wdata_c[8*k +: 8];
                  end
                end
              end
            end
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_COLLECT;
          bvalid_d  = 1'b0;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
        end
      end
    endcase
    awready_d = (w_state_d == W_COLLECT) && !aw_have_d;
    wready_d  = (w_state_d == W_COLLECT) && !w_have_d;
  end

  // Read path: sample the register on AR acceptance, hold until R handshake.
  always_comb begin
    r_state_d  = r_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          rresp_d   = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
          if (rd_ok_c) begin
            for (int unsigned i = 0; i < NREG; i++) begin
              if (32'(ar_idx_c) == i) begin
                rdata_d            = regs_q[i*AXI_DATAW +: AXI_DATAW];
                rd_pulse_d[i +: 1] = 1'b1;
              end
            end
          end
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q  <= W_COLLECT;
      aw_have_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_priv_q  <= 1'b0;
      w_have_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_have_q  <= aw_have_d;
      aw_idx_q   <= aw_idx_d;
      aw_priv_q  <= aw_priv_d;
      w_have_q   <= w_have_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign reg_q    = regs_q;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs (NREG=3 so address 0xC decodes out of range).
module tb_axi_lite_slave_regs;

  localparam int unsigned NREG = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [NREG*32-1:0] reg_q;
  logic [NREG-1:0]   wr_pulse, rd_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mregs [NREG];

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.AXI_DATAW(32), .AXI_ADDRW(4), .AXI_DATAW_BYTE(4), .NREG(NREG)) dut (
    .clk(clk), .rst(rst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: registers as a plain array, byte merge by mask.
  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < NREG; i++) f[i*32 +: 32] = mregs[i];
    return f;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  function automatic bit prot_ok(input logic [2:0] p);
    bit ok = 1'b1;
`ifdef AXI_SLAVE_PROT_EN
    ok = p[0];
`endif
    return ok;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                                      input logic [2:0] p, output logic [1:0] resp,
                                      output logic [NREG-1:0] pulse);
    int idx = a / 4;
    logic [31:0] m = strb_mask(s);
    pulse = '0;
    if (idx < NREG && prot_ok(p)) begin
      mregs[idx] = (mregs[idx] & ~m) | (d & m);
      pulse[idx] = 1'b1;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endfunction

  function automatic void model_read(input logic [3:0] a, input logic [2:0] p, output logic [31:0] d,
                                     output logic [1:0] resp, output logic [NREG-1:0] pulse);
    int idx = a / 4;
    pulse = '0;
    if (idx < NREG && prot_ok(p)) begin
      d = mregs[idx];
      resp = 2'b00;
      pulse[idx] = 1'b1;
    end else begin
      d = '0;
      resp = 2'b10;
    end
  endfunction

  // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, input int gap, input int bdelay,
                           output logic [1:0] resp);
    int aw_t, w_t, cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [1:0] exp_resp;
    logic [NREG-1:0] exp_pulse;
    aw_t = (gap > 0) ? gap : 0;
    w_t  = (gap < 0) ? -gap : 0;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11;
    model_write(a, d, s, p, exp_resp, exp_pulse);
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        check("write_timeout", 1, 0);
        awvalid = 0; wvalid = 0;
        return;
      end
      awaddr = a; awprot = p; wdata = d; wstrb = s;
      awvalid = !aw_done && (cyc >= aw_t);
      wvalid  = !w_done && (cyc >= w_t);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      cyc++;
      if (aw_done != w_done) check("ready_drop", {awready, wready}, {!aw_done, !w_done});
    end
    awvalid = 0; wvalid = 0;
    check("bvalid_set", bvalid, 1);
    check("bresp", bresp, exp_resp);
    check("wr_pulse", wr_pulse, exp_pulse);
    check("reg_q_wr", reg_q, model_flat());
    resp = bresp;
    repeat (bdelay) begin
      @(posedge clk); #1;
      check("b_hold", {bvalid, bresp, awready, wready, wr_pulse}, {1'b1, exp_resp, 2'b00, {NREG{1'b0}}});
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("b_done", {bvalid, awready, wready, wr_pulse}, {3'b011, {NREG{1'b0}}});
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [2:0] p, input int rdelay,
                          output logic [31:0] d, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0] exp_resp;
    logic [NREG-1:0] exp_pulse;
    int cyc = 0;
    d = '0; resp = 2'b11;
    model_read(a, p, exp_d, exp_resp, exp_pulse);
    araddr = a; arprot = p; arvalid = 1;
    while (!arready) begin
      if (cyc > 20) begin
        check("read_timeout", 1, 0);
        arvalid = 0;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    arvalid = 0;
    check("r_first", {rvalid, arready, rresp, rd_pulse}, {2'b10, exp_resp, exp_pulse});
    check("rdata", rdata, exp_d);
    d = rdata; resp = rresp;
    repeat (rdelay) begin
      @(posedge clk); #1;
      check("r_hold", {rvalid, arready, rresp, rdata, rd_pulse}, {2'b10, exp_resp, exp_d, {NREG{1'b0}}});
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("r_done", {rvalid, arready, rd_pulse}, {2'b01, {NREG{1'b0}}});
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;
    int          bdelay;
    int          rdelay;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    logic [1:0] resp, rr, exp_resp;
    logic [31:0] rd;
    vecs[0] = '{4'h4, 32'hDEADBEEF, 4'hF,  0, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{4'h8, 32'h11223344, 4'hF, -2, 0, 1, 2'b00, 32'h11223344, 2'b00};
    vecs[2] = '{4'h8, 32'h000000AA, 4'h1,  3, 5, 0, 2'b00, 32'h112233AA, 2'b00};
    vecs[3] = '{4'h9, 32'h55000000, 4'h8,  0, 1, 2, 2'b00, 32'h552233AA, 2'b00};
    vecs[4] = '{4'hC, 32'hFFFFFFFF, 4'hF,  1, 0, 0, 2'b10, 32'h00000000, 2'b10};
    vecs[5] = '{4'h0, 32'h12345678, 4'h0,  0, 0, 0, 2'b00, 32'h00000000, 2'b00};
    vecs[6] = '{4'h0, 32'hCAFEF00D, 4'h6, -1, 2, 0, 2'b00, 32'h00FEF000, 2'b00};
    vecs[7] = '{4'h7, 32'h00000000, 4'hC,  0, 0, 3, 2'b00, 32'h0000BEEF, 2'b00};

    rst_n = 0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid, bresp, rresp}, 6'b0);
    check("rst_data", {rdata, reg_q, wr_pulse, rd_pulse}, '0);
    rst_n = 1;
    #1;
    check("rel_ready_0", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    check("rel_ready_1", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 3'b001, vecs[i].gap, vecs[i].bdelay, resp);
      check("tbl_bresp", resp, vecs[i].bresp);
      axi_read(vecs[i].addr, 3'b001, vecs[i].rdelay, rd, rr);
      check("tbl_rdata", rd, vecs[i].rdata);
      check("tbl_rresp", rr, vecs[i].rresp);
    end

    // Read accepted on the same edge as a write commit returns the old value.
    axi_write(4'h0, 32'h7, 4'hF, 3'b001, 0, 0, resp);
    check("conc_ready", {awready, wready, arready}, 3'b111);
    awaddr = 4'h0; awprot = 3'b001; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h0; arprot = 3'b001; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    mregs[0] = 32'h55;
    check("conc_rdata", rdata, 32'h7);
    check("conc_flags", {bvalid, bresp, rvalid, rresp, wr_pulse, rd_pulse}, {3'b100, 3'b100, 3'b001, 3'b001});
    check("conc_reg", reg_q, model_flat());
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    check("conc_done", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

    // Protection attributes: rejected only when the feature is compiled in.
`ifdef AXI_SLAVE_PROT_EN
    exp_resp = 2'b10;
`else
    exp_resp = 2'b00;
`endif
    axi_write(4'h0, 32'h1, 4'hF, 3'b000, 0, 0, resp);
    check("prot_w0", resp, exp_resp);
    axi_read(4'h0, 3'b000, 0, rd, rr);
    check("prot_r0", rr, exp_resp);
    axi_write(4'h0, 32'h1, 4'hF, 3'b001, 0, 0, resp);
    check("prot_w1", resp, 2'b00);
    axi_read(4'h0, 3'b001, 0, rd, rr);
    check("prot_r1", rd, 32'h1);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(6)) - 3;
      axi_write(4'($urandom), $urandom, 4'($urandom), 3'($urandom), gap,
                int'($urandom_range(2)), resp);
      axi_read(4'($urandom), 3'($urandom), int'($urandom_range(2)), rd, rr);
    end

    // Reset during a pending read response drops rvalid without waiting for a clock.
    araddr = 4'h4; arprot = 3'b001; arvalid = 1;
    check("mid_ar_ready", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
    check("mid_rvalid", rvalid, 1);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_r", {rvalid, rresp, rdata, rd_pulse}, '0);
    check("mid_rst_w", {bvalid, awready, wready, arready}, 4'b0000);
    check("mid_rst_reg", reg_q, '0);
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_ready", {awready, wready, arready, rvalid}, 4'b1110);
    axi_read(4'h4, 3'b001, 0, rd, rr);
    check("post_rst_read", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
